// File: rtl/doodle_platform_ctrl.sv
// Per-frame platform scheduler: builds the platform table, checks landings,
// scrolls the world with LFSR respawns and accumulates a saturating score.
module doodle_platform_ctrl #(
    parameter int N_PLAT   = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PLAT_W   = 64,
    parameter int PLAT_GAP = 60,
    parameter int MID_Y    = 240,
    parameter int DOODLE_W = 32,
    parameter int HIT_TOL  = 4
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      ack,
    input  logic                      tick,
    input  logic [9:0]                doodle_x,
    input  logic [9:0]                doodle_y,
    input  logic                      falling,
    input  logic [$clog2(N_PLAT)-1:0] rd_idx,
    output logic [9:0]                plat_x,
    output logic [9:0]                plat_y,
    output logic                      hit,
    output logic [9:0]                hit_y,
    output logic                      scroll_valid,
    output logic [9:0]                scroll_amt,
    output logic [15:0]               score,
    output logic                      busy,
    output logic                      game_over
);
    localparam int              IW        = $clog2(N_PLAT);
    localparam logic [IW-1:0]   LAST      = IW'(N_PLAT - 1);
    localparam logic [9:0]      X0        = 10'(SCREEN_W / 2 - PLAT_W / 2);
    localparam logic [9:0]      LFSR_SEED = 10'h2A5;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_CHECK, S_EVAL, S_SCROLL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [9:0]      lfsr_q, lfsr_d;
    logic [9:0]      px_q [N_PLAT];
    logic [9:0]      px_d [N_PLAT];
    logic [9:0]      py_q [N_PLAT];
    logic [9:0]      py_d [N_PLAT];
    logic [9:0]      lx_q, lx_d;
    logic [9:0]      ly_q, ly_d;
    logic            lf_q, lf_d;
    logic            found_q, found_d;
    logic [9:0]      match_y_q, match_y_d;
    logic [15:0]     score_q, score_d;

    logic [9:0]      lfsr_next;
    logic [10:0]     dx_w, dy_w, px_w, py_w;
    logic            cur_match;
    logic [9:0]      amt;
    logic [10:0]     scroll_sum;
    logic [16:0]     score_sum;

    assign lfsr_next = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    // Landing test for the entry under cnt_q; 11-bit operands keep edge sums from wrapping.
    assign dx_w      = {1'b0, lx_q};
    assign dy_w      = {1'b0, ly_q};
    assign px_w      = {1'b0, px_q[cnt_q]};
    assign py_w      = {1'b0, py_q[cnt_q]};
    assign cur_match = lf_q
                     && (dx_w + 11'(DOODLE_W) > px_w)
                     && (dx_w < px_w + 11'(PLAT_W))
                     && (py_w <= dy_w)
                     && (dy_w <= py_w + 11'(HIT_TOL));

    assign amt        = 10'(MID_Y) - ly_q;
    assign scroll_sum = {1'b0, py_q[cnt_q]} + {1'b0, amt};
    assign score_sum  = {1'b0, score_q} + {7'd0, amt};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        px_d         = px_q;
        py_d         = py_q;
        lx_d         = lx_q;
        ly_d         = ly_q;
        lf_d         = lf_q;
        found_d      = found_q;
        match_y_d    = match_y_q;
        score_d      = score_q;
        hit          = 1'b0;
        hit_y        = '0;
        scroll_valid = 1'b0;
        scroll_amt   = '0;

        // hit and scroll_valid are single-cycle pulses with no back-pressure;
        // hit_y and scroll_amt are only meaningful while their pulse is high.
        unique case (state_q)
            S_IDLE: begin
                score_d = '0;
                cnt_d   = '0;
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                py_d[cnt_q] = 10'(SCREEN_H - PLAT_GAP * (int'(cnt_q) + 1));
                if (cnt_q == '0) begin
                    px_d[cnt_q] = X0;
                end else begin
                    px_d[cnt_q] = {1'b0, lfsr_q[8:0]};
                    lfsr_d      = lfsr_next;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = '0;
                if (tick) begin
                    lx_d    = doodle_x;
                    ly_d    = doodle_y;
                    lf_d    = falling;
                    found_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!found_q && cur_match) begin
                    found_d   = 1'b1;
                    match_y_d = py_q[cnt_q];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_EVAL;
            end
            S_EVAL: begin
                cnt_d = '0;
                if (found_q) begin
                    hit     = 1'b1;
                    hit_y   = match_y_q;
                    state_d = S_SCROLL;
                end else if (ly_q >= 10'(SCREEN_H)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (ly_q >= 10'(MID_Y)) begin
                    state_d = S_WAIT;
                end else begin
                    // Platforms pushed off the bottom re-enter at the top with a fresh x.
                    if (scroll_sum >= 11'(SCREEN_H)) begin
                        py_d[cnt_q] = 10'(scroll_sum - 11'(SCREEN_H));
                        px_d[cnt_q] = {1'b0, lfsr_q[8:0]};
                        lfsr_d      = lfsr_next;
                    end else begin
                        py_d[cnt_q] = scroll_sum[9:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        scroll_valid = 1'b1;
                        scroll_amt   = amt;
                        score_d      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        state_d      = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            lx_q      <= '0;
            ly_q      <= '0;
            lf_q      <= 1'b0;
            found_q   <= 1'b0;
            match_y_q <= '0;
            score_q   <= '0;
            for (int i = 0; i < N_PLAT; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            lf_q      <= lf_d;
            found_q   <= found_d;
            match_y_q <= match_y_d;
            score_q   <= score_d;
            for (int i = 0; i < N_PLAT; i++) begin
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
            end
        end
    end

    assign plat_x    = px_q[rd_idx];
    assign plat_y    = py_q[rd_idx];
    assign score     = score_q;
    assign busy      = (state_q == S_INIT) || (state_q == S_CHECK)
                    || (state_q == S_EVAL) || (state_q == S_SCROLL);
    assign game_over = (state_q == S_DONE);

endmodule

// File: tb/tb_doodle_platform_ctrl.sv
// Randomized frame-level bench for doodle_platform_ctrl against a table model
// that predicts every output cycle of each frame from the game rules.
module tb_doodle_platform_ctrl;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic        pchk;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hit;
        logic [9:0]  hy;
        logic        sv;
        logic [9:0]  amt;
        logic        busy;
        logic        go;
        logic [15:0] score;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic          Clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic          tick = 1'b0;
    logic          falling = 1'b0;
    logic [9:0]    doodle_x = '0;
    logic [9:0]    doodle_y = '0;
    logic [IW-1:0] rd_idx = '0;
    logic [9:0]    plat_x, plat_y, hit_y, scroll_amt;
    logic          hit, scroll_valid, busy, game_over;
    logic [15:0]   score;

    int            drv_dx, drv_dy;
    logic          drv_f;
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    int            m_px[N];
    int            m_py[N];
    int            m_score;
    int            m_hy;
    logic [9:0]    m_lfsr;

    doodle_platform_ctrl #(.N_PLAT(N)) dut (
        .Clk(Clk), .reset(reset), .start(start), .ack(ack), .tick(tick),
        .doodle_x(doodle_x), .doodle_y(doodle_y), .falling(falling), .rd_idx(rd_idx),
        .plat_x(plat_x), .plat_y(plat_y), .hit(hit), .hit_y(hit_y),
        .scroll_valid(scroll_valid), .scroll_amt(scroll_amt), .score(score),
        .busy(busy), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic logic [EW-1:0] mk(input bit pc, input int px, input int py, input bit h,
                                         input int hy, input bit sv, input int amt, input bit b,
                                         input bit g, input int sc);
        exp_t e;
        e.pchk = pc;  e.px = 10'(px);  e.py = 10'(py);  e.hit = h;  e.hy = 10'(hy);
        e.sv = sv;    e.amt = 10'(amt); e.busy = b;     e.go = g;   e.score = 16'(sc);
        return e;
    endfunction

    function automatic logic [EW-1:0] e_busy();
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, m_score);
    endfunction

    function automatic logic [EW-1:0] e_wait(input int r, input bit go);
        return mk(1, m_px[r], m_py[r], 0, 0, 0, 0, 0, go, m_score);
    endfunction

    // Scoreboard: one expected output vector per clock, sampled 1 time unit after the edge.
    always begin : cmp_proc
        exp_t e;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("busy", 32'(busy), 32'(e.busy));
            chk("game_over", 32'(game_over), 32'(e.go));
            chk("hit", 32'(hit), 32'(e.hit));
            chk("scroll_valid", 32'(scroll_valid), 32'(e.sv));
            chk("score", 32'(score), 32'(e.score));
            if (e.hit) chk("hit_y", 32'(hit_y), 32'(e.hy));
            if (e.sv) chk("scroll_amt", 32'(scroll_amt), 32'(e.amt));
            if (e.pchk) begin
                chk("plat_x", 32'(plat_x), 32'(e.px));
                chk("plat_y", 32'(plat_y), 32'(e.py));
            end
        end
    end

    task automatic step(input logic t, input logic s, input logic a, input int r,
                        input logic [EW-1:0] e);
        @(negedge Clk);
        tick = t; start = s; ack = a; rd_idx = IW'(r);
        doodle_x = 10'(drv_dx); doodle_y = 10'(drv_dy); falling = drv_f;
        exp_q.push_back(e);
    endtask

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        @(posedge Clk);
        #3;
        reset = 1'b1; tick = 1'b0; start = 1'b0; ack = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_hit_y", 32'(hit_y), 0);
        chk("rst_scroll_valid", 32'(scroll_valid), 0);
        chk("rst_scroll_amt", 32'(scroll_amt), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_plat_x", 32'(plat_x), 0);
        chk("rst_plat_y", 32'(plat_y), 0);
        m_lfsr = 10'h2A5;
        m_score = 0;
        for (int i = 0; i < N; i++) begin
            m_px[i] = 0;
            m_py[i] = 0;
        end
        for (int i = 0; i < N; i++) step(0, 0, 0, i, e_wait(i, 0));
        @(negedge Clk);
        reset = 1'b0;
    endtask

    task automatic start_game();
        m_score = 0;
        m_px[0] = 288;
        for (int i = 1; i < N; i++) begin
            m_px[i] = int'(m_lfsr[8:0]);
            m_lfsr = lfsr_step(m_lfsr);
        end
        for (int i = 0; i < N; i++) m_py[i] = 480 - 60 * (i + 1);
        step(0, 1, 0, 0, e_busy());
        for (int j = 1; j < N; j++) step(rnd1(), rnd1(), 0, 0, e_busy());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            int r;
            r = $urandom_range(0, N - 1);
            step(0, rnd1(), rnd1(), r, e_wait(r, 0));
        end
    endtask

    task automatic read_check(input int idx, input int ex, input int ey);
        step(0, 0, 0, idx, e_wait(idx, 0));
        @(posedge Clk);
        #2;
        if (ex >= 0) chk("lit_plat_x", 32'(plat_x), 32'(ex));
        chk("lit_plat_y", 32'(plat_y), 32'(ey));
    endtask

    task automatic frame(input int dx, input int dy, input logic f, input int stop_at);
        int hit_i, amt, r, y;
        hit_i = -1;
        for (int i = 0; i < N; i++)
            if (hit_i < 0 && f && dx + 32 > m_px[i] && dx < m_px[i] + 64
                && m_py[i] <= dy && dy <= m_py[i] + 4) hit_i = i;
        m_hy = (hit_i >= 0) ? m_py[hit_i] : 0;
        drv_dx = dx; drv_dy = dy; drv_f = f;
        step(1, 0, 0, 0, e_busy());
        drv_dx = $urandom_range(0, 639); drv_dy = $urandom_range(0, 520); drv_f = rnd1();
        for (int j = 1; j < N; j++) step(rnd1(), rnd1(), rnd1(), 0, e_busy());
        step(rnd1(), rnd1(), 0, 0, mk(0, 0, 0, hit_i >= 0, m_hy, 0, 0, 1, 0, m_score));
        r = $urandom_range(0, N - 1);
        if (hit_i < 0 && dy >= 480) begin
            step(rnd1(), rnd1(), 0, r, e_wait(r, 1));
        end else if (dy >= 240) begin
            step(rnd1(), rnd1(), 0, 0, e_busy());
            step(rnd1(), rnd1(), 0, r, e_wait(r, 0));
        end else begin
            amt = 240 - dy;
            for (int j = N + 1; j < 2 * N; j++) begin
                if (j == stop_at) return;
                step(rnd1(), rnd1(), 0, 0, e_busy());
            end
            step(rnd1(), rnd1(), 0, 0, mk(0, 0, 0, 0, 0, 1, amt, 1, 0, m_score));
            for (int i = 0; i < N; i++) begin
                y = m_py[i] + amt;
                if (y >= 480) begin
                    y -= 480;
                    m_px[i] = int'(m_lfsr[8:0]);
                    m_lfsr = lfsr_step(m_lfsr);
                end
                m_py[i] = y;
            end
            m_score = (m_score + amt > 65535) ? 65535 : m_score + amt;
            step(rnd1(), rnd1(), 0, r, e_wait(r, 0));
        end
    endtask

    initial begin
        int k, dx, dy;
        logic f;
        drv_dx = 0; drv_dy = 0; drv_f = 1'b0;
        do_reset();
        start_game();
        idle(N + 2);
        read_check(0, 288, 420);
        read_check(1, 165, 360);
        read_check(2, 331, 300);
        read_check(7, -1, 0);

        frame(300, 422, 1'b1, -1);
        chk("pin_model_hit_y", 32'(m_hy), 420);
        idle(3);
        frame(300, 422, 1'b0, -1);
        idle(2);
        frame(200, 422, 1'b1, -1);
        idle(2);
        frame(600, 200, 1'b0, -1);
        chk("pin_model_score", 32'(m_score), 40);
        chk("pin_model_y0", 32'(m_py[0]), 460);
        chk("pin_model_y7", 32'(m_py[7]), 40);
        read_check(0, 288, 460);
        read_check(7, -1, 40);
        chk("lit_score_40", 32'(score), 40);
        idle(N);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, N - 1);
            dx = m_px[k] + $urandom_range(0, 110) - 40;
            dx = (dx < 0) ? 0 : (dx > 639) ? 639 : dx;
            dy = m_py[k] + $urandom_range(0, 9) - 3;
            if ($urandom_range(0, 3) == 0) dy = $urandom_range(100, 239);
            dy = (dy < 0) ? 0 : (dy > 479) ? 479 : dy;
            f = ($urandom_range(0, 3) != 0);
            frame(dx, dy, f, -1);
            idle($urandom_range(1, 4));
        end

        for (int n = 0; n < 275; n++) begin
            frame($urandom_range(0, 639), 0, 1'b0, -1);
            idle(1);
        end
        read_check(3, m_px[3], m_py[3]);
        chk("lit_score_sat", 32'(score), 32'hFFFF);

        frame(600, 480, 1'b0, -1);
        for (int n = 0; n < 4; n++) begin
            k = $urandom_range(0, N - 1);
            step(rnd1(), 1, 0, k, e_wait(k, 1));
        end
        k = $urandom_range(0, N - 1);
        step(0, 0, 1, k, e_wait(k, 0));
        start_game();
        idle(N);
        frame(300, 422, 1'b1, -1);
        idle(2);

        frame(600, 150, 1'b0, 12);
        do_reset();
        start_game();
        idle(N);
        read_check(1, 165, 360);
        read_check(2, 331, 300);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/doodle_platform_ctrl.md
Name: doodle_platform_ctrl

Overview:
- Per-frame platform scheduler for the doodle game, between the frame-tick generator, the doodle jump state machine and the VGA renderer.
- Owns the platform table and answers the three questions the jump FSM needs each frame: landed on a block, above the middle (scroll), fell off the bottom (game over).
- Also performs the scroll, respawns platforms with pseudo-random x, and accumulates score.

Parameters:
N_PLAT, 8, platform table entries (power of 2, 2..16)
SCREEN_W, 640, screen width in pixels
SCREEN_H, 480, screen height in pixels
PLAT_W, 64, platform width
PLAT_GAP, 60, initial vertical spacing
MID_Y, 240, scroll threshold row
DOODLE_W, 32, doodle width
HIT_TOL, 4, landing tolerance below platform top

Ports:
Clk  in  1  clock
reset  in  1  async active-high reset
start  in  1  leave IDLE, build table
ack  in  1  leave DONE
tick  in  1  one-cycle frame pulse
doodle_x  in  10  doodle left edge
doodle_y  in  10  doodle bottom edge (y grows downward)
falling  in  1  jump FSM is in DOWN
rd_idx  in  log2(N_PLAT)  renderer read index
plat_x  out  10  x of entry rd_idx (combinational read)
plat_y  out  10  y of entry rd_idx (combinational read)
hit  out  1  one-cycle landing pulse
hit_y  out  10  top y of landed platform, valid with hit
scroll_valid  out  1  one-cycle pulse, scroll applied
scroll_amt  out  10  pixels scrolled, valid with scroll_valid
score  out  16  accumulated scroll distance, saturating
busy  out  1  high in INIT/CHECK/EVAL/SCROLL
game_over  out  1  high in DONE

Behaviour:
- Reset is asynchronous, active-high; clock is Clk. Reset puts state in IDLE, clears all outputs and table entries to 0 and loads LFSR with 10'h2A5. Reset mid-operation aborts immediately.
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1. Advances only on a table write that uses a random x.
- States: IDLE, INIT, WAIT, CHECK, EVAL, SCROLL, DONE.
- IDLE: start moves to INIT. Score cleared.
- INIT (N_PLAT cycles, entry i on cycle i):
  - y = SCREEN_H - PLAT_GAP*(i+1).
  - Entry 0 x = SCREEN_W/2 - PLAT_W/2 (288). Other entries x = lfsr[8:0].
  - Then WAIT.
- WAIT: tick latches doodle_x, doodle_y and falling, then moves to CHECK. Ticks in any other state are ignored (no queueing).
- CHECK (N_PLAT cycles, one entry per cycle). Entry i matches when all hold, using latched values:
  - falling=1
  - doodle_x + DOODLE_W > px
  - doodle_x < px + PLAT_W
  - py <= doodle_y <= py + HIT_TOL
  - The lowest-index match is recorded. Arithmetic is 11-bit so no wrap.
- EVAL (1 cycle), first true rule wins:
  1. Match found: pulse hit, hit_y = matched py, go to SCROLL.
  2. No match and doodle_y >= SCREEN_H: go to DONE.
  3. Otherwise go to SCROLL.
- SCROLL:
  - If latched doodle_y >= MID_Y: return to WAIT in 1 cycle, no pulse.
  - Else amt = MID_Y - doodle_y. Over N_PLAT cycles, each y += amt. If the result >= SCREEN_H, y -= SCREEN_H and x gets a new lfsr[8:0].
  - On the final cycle: scroll_valid=1, scroll_amt=amt, score += amt (saturating at 16'hFFFF). Then WAIT.
- Latency, tick to hit: N_PLAT+1 cycles. Tick to scroll_valid: 2*N_PLAT+1 cycles.
- A hit and a scroll may occur in the same frame.
- DONE: game_over=1 and table frozen. ack moves to IDLE; start is ignored.
- plat_x/plat_y are a combinational table read and are valid in every state, including mid-scroll (mixed old/new values allowed).

Test Plan:
- Reset, then start → busy high 8 cycles. Then entry 0 = (288,420), entry 7 y = 0, and 7 x values from the LFSR sequence starting at 2A5, all < 512.
- tick with doodle (300,422), falling=1 → hit pulse 9 cycles after tick, hit_y=420, no scroll, busy low at cycle 11.
- tick with doodle (300,422), falling=0 → no hit. Same with doodle_x=200 (right edge 232 < 288) → no hit.
- tick with doodle_y=200, no match → scroll_valid at cycle 17, scroll_amt=40, score=40, entry 0 y=460, entry 7 y=40. Entries pushed >=480 wrap with fresh x.
- tick with doodle_y=480, no match → game_over. Then tick ignored, ack → IDLE, start → INIT with score=0.
- tick during CHECK is ignored; reset asserted mid-SCROLL → IDLE, all outputs 0, LFSR = 2A5.
